// File: rtl/ram_scanner_pkg.sv
// ram_scanner_pkg
// Shared types and helpers for the RAM scanner block.
//   scan_state_t : controller state (normal scanning or hardware clear)
//   depth()      : number of memory words for a given address width
package ram_scanner_pkg;

    typedef enum logic {
        SCAN  = 1'b0,
        CLEAR = 1'b1
    } scan_state_t;

    function automatic int unsigned depth(input int unsigned addr_w);
        return 32'd1 << addr_w;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen
// Scan-rate prescaler. Counts 0..TICK_DIV-1 while enabled and raises a
// one-cycle tick on the last count, then restarts from 0.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   en    : count enable; the count holds while low
//   clr   : synchronous restart to 0 (takes priority over en)
//   tick  : one-cycle pulse every TICK_DIV enabled cycles
module tick_gen
    import ram_scanner_pkg::*;
#(
    parameter int unsigned TICK_DIV = 37500000,
    parameter int unsigned TICK_W   = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

    logic [TICK_W-1:0] cnt;

    // Tick is decoded from the current count so the advance lands on the
    // edge that closes the TICK_DIV-th enabled cycle.
    assign tick = en && (cnt == LAST);

    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_scanner.sv
// ram_scanner
// Dual-port RAM with an auto-incrementing read scanner, write-first
// collision bypass and a hardware clear sequencer.
//   clk       : system clock
//   reset     : asynchronous active-low reset
//   wr_en     : user write strobe (ignored while clearing)
//   wr_addr   : user write address
//   wr_data   : user write data
//   scan_en   : 1 = advance rd_addr on every prescaler tick
//   step      : single advance when scan_en = 0
//   clear_req : start zeroing every word
//   rd_addr   : current scanner address
//   rd_data   : registered mem[rd_addr], write-first on collision
//   wrap      : one-cycle pulse on the last-to-0 address transition
//   busy      : high while the clear sequence runs
module ram_scanner
    import ram_scanner_pkg::*;
#(
    parameter int unsigned DATA_W   = 4,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned TICK_DIV = 37500000,
    parameter int unsigned TICK_W   = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              scan_en,
    input  logic              step,
    input  logic              clear_req,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              wrap,
    output logic              busy
);

    localparam int unsigned       DEPTH     = depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    scan_state_t       state, state_next;
    logic [ADDR_W-1:0] ptr, ptr_next;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              tick, tick_en, tick_clr;
    logic              advance;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // The prescaler only runs while scanning; holding it cleared through a
    // clear sequence guarantees a fresh count when scanning resumes.
    assign tick_en  = scan_en && (state == SCAN);
    assign tick_clr = (state == CLEAR);

    tick_gen #(
        .TICK_DIV (TICK_DIV),
        .TICK_W   (TICK_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    // Next-state and write-port selection. The single memory write port is
    // shared: the user owns it in SCAN, the clear pointer owns it in CLEAR.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_next = state;
        ptr_next   = ptr;
        advance    = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_data;

        unique case (state)
            SCAN: begin
                // A step pulse is only honoured while auto-scan is off.
                advance = scan_en ? tick : step;
                if (clear_req) begin
                    // Clear wins over a same-cycle user write.
                    state_next = CLEAR;
                    ptr_next   = '0;
                end else if (wr_en) begin
                    mem_we = 1'b1;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdata = '0;
                ptr_next  = ptr + 1'b1;
                if (ptr == LAST_ADDR) begin
                    state_next = SCAN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            ptr     <= '0;
            rd_addr <= '0;
            rd_data <= '0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            // Write-first: a write to the word being read is forwarded so
            // rd_data shows the new value on the same edge as the write.
            rd_data <= (mem_we && (mem_waddr == rd_addr)) ? mem_wdata : mem[rd_addr];
            wrap    <= advance && (rd_addr == LAST_ADDR);
            if (advance) begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; contents are
    // only ever changed by writes, including the clear sequence.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign busy = (state == CLEAR);

endmodule

// File: doc/ram_scanner.md
Name: ram_scanner

Overview:
- Parametrised dual-port RAM with an auto-incrementing read scanner, a write-first collision bypass and a hardware clear sequencer.
- Sits between board inputs (switch write port, key controls) and HEX display logic; generalises the fixed 32x4 counter-read RAM to arbitrary width and depth.
- Adds programmable scan rate, pause and single-step control, a wrap pulse and a clear state machine.

Parameters:
- DATA_W, 4, width of each memory word.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- TICK_DIV, 37500000, clk cycles per scan step (minimum 1); benches use 4.
- TICK_W, 26, prescaler counter width; must satisfy 2**TICK_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_en  in  1  write strobe, sampled each clk.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- scan_en  in  1  1 = auto-advance read address on each tick.
- step  in  1  single-cycle pulse: advance read address by one when scan_en=0.
- clear_req  in  1  single-cycle pulse: start clearing all words to 0.
- rd_addr  out  ADDR_W  current scanner read address.
- rd_data  out  DATA_W  registered read data for rd_addr.
- wrap  out  1  one-cycle pulse when rd_addr advances from 2**ADDR_W-1 to 0.
- busy  out  1  high while clear sequence runs.

Behaviour:
- Reset (reset=0, asynchronous): rd_addr=0, rd_data=0, wrap=0, busy=0, prescaler=0, state=SCAN. Memory contents are not reset.
- Prescaler: counts 0..TICK_DIV-1 while state=SCAN and scan_en=1, then emits a one-cycle tick and reloads 0. It holds its value while scan_en=0 and resets to 0 on entering SCAN.
- Advance event: a tick (scan_en=1) or a step pulse (scan_en=0). A step pulse while scan_en=1 is ignored.
- Address update: rd_addr increments modulo 2**ADDR_W on the clk edge after the advance event. wrap asserts on the same edge as the transition from max to 0.
- Read latency: rd_data is updated each cycle with mem[rd_addr], so it is valid 1 cycle after rd_addr changes.
- Write: when wr_en=1 and state=SCAN, mem[wr_addr] <= wr_data at the clk edge.
- Collision (wr_en=1, wr_addr==rd_addr, same cycle): write-first. rd_data receives wr_data on that edge, not the old word.
- FSM states: SCAN and CLEAR (enum in package).
  - SCAN -> CLEAR on clear_req=1. The clear pointer loads 0, busy=1 from the next edge, and rd_addr holds.
  - CLEAR: writes 0 to mem[ptr] each cycle and increments ptr. After writing address 2**ADDR_W-1, returns to SCAN with busy=0 and prescaler=0.
  - The clear takes exactly 2**ADDR_W cycles with busy high.
  - In CLEAR, wr_en, step, scan and clear_req are ignored. rd_data continues to read mem[rd_addr] and follows the clear write-first when ptr==rd_addr.
- clear_req and wr_en in the same cycle: clear wins and the user write is dropped.
- Reset mid-clear: the FSM returns to SCAN and busy=0 immediately. The partially cleared memory is left as is.
- All counters are unsigned and wrap naturally. No arithmetic saturation anywhere.

Decomposition:
- Package ram_scanner_pkg: scan_state_t enum {SCAN, CLEAR}, and a localparam function depth(ADDR_W).
- Sub-module tick_gen (params TICK_DIV, TICK_W; ports clk, reset, en, tick). Instantiated once; en = scan_en && state==SCAN.
- Memory is inferred inside ram_scanner as a dual-port array with the bypass mux.

Test Plan (ADDR_W=5, DATA_W=4, TICK_DIV=4):
- Reset check: reset=0 for 2 cycles -> rd_addr=0, rd_data=0, wrap=0, busy=0. Release reset with scan_en=0 -> rd_addr stays 0 for 10 cycles.
- Write/read: write 4'h1 to address 7, then 4'hF to address 3. With scan_en=0, pulse step 3 times -> rd_addr=3, and rd_data=4'hF one cycle later. Pulse step 4 more times -> rd_addr=7, rd_data=4'h1.
- Auto scan and wrap: scan_en=1 from rd_addr=0 -> rd_addr advances every 4 cycles. After 128 cycles rd_addr returns to 0 with exactly one wrap pulse on that edge. Pulsing step during the scan has no effect.
- Collision: rd_addr=5 holds 4'h2; write 4'hA to address 5 with scan_en=0 -> rd_data=4'hA on the same edge as the write.
- Clear: load addresses 0, 7 and 31 with nonzero data, then pulse clear_req -> busy high for exactly 32 cycles. A wr_en issued during the clear is dropped. Afterwards, stepping through all addresses reads 0.
- Reset mid-clear: assert reset 10 cycles into a clear -> busy=0 and rd_addr=0 immediately. Addresses 0..9 read 0 and address 31 keeps its prior value.
